// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that serialises NUM_REQ requesters onto one I2C master command port.
// Each granted transaction is launched, supervised with start/done timeouts, and completed with a done pulse.
module i2c_req_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int START_TMO = 1023,
  parameter int DONE_TMO  = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [10*NUM_REQ-1:0]  req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic [7:0]             rdata,
  output logic                   drv_start,
  output logic                   drv_rw,
  output logic [9:0]             drv_addr,
  output logic [7:0]             drv_wdata,
  input  logic                   drv_busy,
  input  logic [7:0]             drv_rdata
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_TMO = (START_TMO > DONE_TMO) ? START_TMO : DONE_TMO;
  localparam int CNT_W   = $clog2(MAX_TMO) + 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TMO);
  localparam logic [CNT_W-1:0] DONE_LIM  = CNT_W'(DONE_TMO);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_LAUNCH    = 3'd2,
    S_WAIT_RISE = 3'd3,
    S_WAIT_FALL = 3'd4,
    S_COMPLETE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   win_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               rw_q;
  logic [9:0]         addr_q;
  logic [7:0]         wdata_q;
  logic [7:0]         rdata_q;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [CNT_W-1:0]   cnt_sat;
  logic               start_tmo_hit;
  logic               done_tmo_hit;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    int slot;
    slot     = 0;
    pick_idx = ptr_q;
    pick_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      slot = int'(ptr_q) + k;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      if (req[slot]) begin
        pick_idx = slot[IDX_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  assign cnt_sat       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign start_tmo_hit = (cnt_sat >= START_LIM);
  assign done_tmo_hit  = (cnt_sat >= DONE_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!drv_busy && |req) state_d = S_ARB;
      S_ARB:       state_d = pick_vld ? S_LAUNCH : S_IDLE;
      S_LAUNCH:    state_d = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (drv_busy)           state_d = S_WAIT_FALL;
        else if (start_tmo_hit) state_d = S_COMPLETE;
      end
      S_WAIT_FALL: begin
        if (!drv_busy)         state_d = S_COMPLETE;
        else if (done_tmo_hit) state_d = S_COMPLETE;
      end
      S_COMPLETE:  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Busy wins over a coincident timeout; read data is captured on the fall so it is valid with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_ARB: begin
          err_q <= 1'b0;
          if (pick_vld) begin
            win_q   <= pick_idx;
            rw_q    <= req_rw[pick_idx];
            addr_q  <= req_addr[int'(pick_idx)*10 +: 10];
            wdata_q <= req_wdata[int'(pick_idx)*8 +: 8];
          end
        end
        S_LAUNCH: cnt_q <= '0;
        S_WAIT_RISE: begin
          if (drv_busy) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_sat;
            if (start_tmo_hit) err_q <= 1'b1;
          end
        end
        S_WAIT_FALL: begin
          if (!drv_busy) begin
            if (rw_q) rdata_q <= drv_rdata;
          end else begin
            cnt_q <= cnt_sat;
            if (done_tmo_hit) err_q <= 1'b1;
          end
        end
        S_COMPLETE: ptr_q <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt       = '0;
    done      = '0;
    err       = 1'b0;
    drv_start = 1'b0;
    case (state_q)
      S_LAUNCH: begin
        gnt[win_q] = 1'b1;
        drv_start  = 1'b1;
      end
      S_WAIT_RISE, S_WAIT_FALL: gnt[win_q] = 1'b1;
      S_COMPLETE: begin
        gnt[win_q]  = 1'b1;
        done[win_q] = 1'b1;
        err         = err_q;
      end
      default: ;
    endcase
  end

  assign drv_rw    = rw_q;
  assign drv_addr  = addr_q;
  assign drv_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: table-driven transactions, hand-written corner sequences,
// and randomized transactions checked against a transaction-level model.
module tb_i2c_req_arbiter;
  localparam int N  = 4;
  localparam int ST = 15;
  localparam int DT = 31;

  logic        clk, rst;
  logic [3:0]  req, req_rw;
  logic [39:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  gnt, done;
  logic        err;
  logic [7:0]  rdata;
  logic        drv_start, drv_rw;
  logic [9:0]  drv_addr;
  logic [7:0]  drv_wdata;
  logic        drv_busy;
  logic [7:0]  drv_rdata;

  int         total = 0;
  int         bad   = 0;
  int         ptr_m = 0;
  logic [7:0] rdata_m = 8'h00;

  i2c_req_arbiter #(.NUM_REQ(N), .START_TMO(ST), .DONE_TMO(DT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .drv_start(drv_start), .drv_rw(drv_rw), .drv_addr(drv_addr),
    .drv_wdata(drv_wdata), .drv_busy(drv_busy), .drv_rdata(drv_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] rw;
    logic [9:0] addr;
    logic [7:0] wdata;
    int         d;
    int         h;
    logic [7:0] rd;
    int         exp_w;
    bit         exp_e;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int j = 0; j < N; j++)
      if (r[(p + j) % N]) return (p + j) % N;
    return -1;
  endfunction

  // Busy must rise within ST cycles and then fall within DT cycles; done follows one cycle later.
  function automatic int done_at(input int d, input int h, output bit e);
    if (d < 1 || d > ST) begin
      e = 1'b1;
      return ST + 1;
    end
    if (h <= DT) begin
      e = 1'b0;
      return d + h + 1;
    end
    e = 1'b1;
    return d + DT + 1;
  endfunction

  // d<0: busy never rises; busy high on cycles d..d+h-1 after drv_start.
  task automatic txn(input logic [3:0] r, input logic [3:0] rw, input logic [9:0] abase,
                     input logic [7:0] wbase, input int d, input int h, input logic [7:0] rd,
                     input int exp_w, input bit exp_e, input logic [3:0] after,
                     input bit scramble, input string nm);
    int         n;
    int         done_k;
    bit         seen;
    bit         e_unused;
    logic [9:0] ea;
    logic [7:0] ew;
    logic       erw;
    @(negedge clk);
    chk({nm, "_idle_gnt"}, 64'(gnt), 64'(0));
    req    = r;
    req_rw = rw;
    for (int i = 0; i < N; i++) begin
      req_addr[i*10 +: 10] = abase + 10'(i * 65);
      req_wdata[i*8 +: 8]  = wbase + 8'(i);
    end
    ea   = abase + 10'(exp_w * 65);
    ew   = wbase + 8'(exp_w);
    erw  = rw[exp_w];
    seen = 1'b0;
    n    = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      n = c;
      if (drv_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, "_start_lat"}, 64'(seen ? n : 99), 64'(2));
    if (!seen) return;
    chk({nm, "_gnt"}, 64'(gnt), 64'(1) << exp_w);
    chk({nm, "_drv_rw"}, 64'(drv_rw), 64'(erw));
    chk({nm, "_drv_addr"}, 64'(drv_addr), 64'(ea));
    chk({nm, "_drv_wdata"}, 64'(drv_wdata), 64'(ew));
    if (scramble) begin
      req       = 4'($urandom);
      req_rw    = 4'($urandom);
      req_addr  = {$urandom, $urandom};
      req_wdata = $urandom;
    end
    drv_rdata = rd;
    done_k = done_at(d, h, e_unused);
    for (int k = 1; k <= done_k && k < 300; k++) begin
      @(negedge clk);
      chk({nm, "_gnt_onehot"}, 64'($onehot0(gnt)), 64'(1));
      chk({nm, "_done_onehot"}, 64'($onehot0(done)), 64'(1));
      if (k < done_k) begin
        chk({nm, "_early_done"}, 64'(done), 64'(0));
        chk({nm, "_extra_start"}, 64'(drv_start), 64'(0));
        drv_busy = (d > 0) && (k >= d) && (k < d + h);
      end
    end
    chk({nm, "_done"}, 64'(done), 64'(1) << exp_w);
    chk({nm, "_err"}, 64'(err), 64'(exp_e));
    if (erw && !exp_e) rdata_m = rd;
    chk({nm, "_rdata"}, 64'(rdata), 64'(rdata_m));
    chk({nm, "_hold_addr"}, 64'(drv_addr), 64'(ea));
    chk({nm, "_hold_wdata"}, 64'(drv_wdata), 64'(ew));
    ptr_m    = (exp_w + 1) % N;
    drv_busy = 1'b0;
    req      = after;
  endtask

  initial begin
    int   fair_w[5];
    int   n;
    bit   seen;
    logic [3:0] r, rw, aft;
    logic [9:0] a;
    logic [7:0] w, rd;
    int   d, h, sel, ew;
    bit   e;

    tbl[0] = '{4'b0001, 4'b0000, 10'h2A5, 8'h5C,  2,   20, 8'h00, 0, 1'b0};
    tbl[1] = '{4'b0100, 4'b0100, 10'h100, 8'h11,  3,    5, 8'hA7, 2, 1'b0};
    tbl[2] = '{4'b1111, 4'b0000, 10'h3F0, 8'h20,  1,    1, 8'h44, 3, 1'b0};
    tbl[3] = '{4'b0110, 4'b0010, 10'h055, 8'h30,  1,   DT, 8'h3C, 1, 1'b0};
    tbl[4] = '{4'b0011, 4'b0001, 10'h1C3, 8'h40,  ST,   2, 8'h5E, 0, 1'b0};
    tbl[5] = '{4'b0010, 4'b0010, 10'h0F0, 8'h50, -1,    0, 8'h99, 1, 1'b1};
    tbl[6] = '{4'b1000, 4'b1000, 10'h222, 8'h60,  2, 1000, 8'h77, 3, 1'b1};
    tbl[7] = '{4'b1000, 4'b0000, 10'h333, 8'h70,  1,    3, 8'h88, 3, 1'b0};
    fair_w = '{0, 1, 2, 3, 0};

    rst = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    drv_busy = 1'b0; drv_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_start", 64'(drv_start), 64'(0));
    chk("rst_drv", 64'({drv_rw, drv_addr, drv_wdata}), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      txn(tbl[i].req, tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].d, tbl[i].h, tbl[i].rd,
          tbl[i].exp_w, tbl[i].exp_e, 4'b0000, 1'b1, $sformatf("vec%0d", i));

    // Fairness with all requests held high.
    for (int i = 0; i < 5; i++)
      txn(4'b1111, 4'b0000, 10'h011, 8'h22, 1, 2, 8'h00, fair_w[i], 1'b0,
          (i < 4) ? 4'b1111 : 4'b0000, 1'b0, $sformatf("fair%0d", i));

    // Master busy while idle: no grant may be issued.
    @(negedge clk);
    drv_busy = 1'b1;
    req      = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("busy_idle_gnt", 64'(gnt), 64'(0));
      chk("busy_idle_start", 64'(drv_start), 64'(0));
    end
    drv_busy = 1'b0;
    req      = 4'b0000;

    // Reset while waiting for busy to fall.
    @(negedge clk);
    req  = 4'b0100;
    seen = 1'b0;
    n    = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      n = c;
      if (drv_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rstmid_start_lat", 64'(seen ? n : 99), 64'(2));
    chk("rstmid_gnt", 64'(gnt), 64'(1) << pick(4'b0100, ptr_m));
    drv_busy = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstmid_busy_gnt", 64'(gnt), 64'(4'b0100));
    rst = 1'b1;
    #1;
    chk("rstmid_gnt_drop", 64'(gnt), 64'(0));
    chk("rstmid_done", 64'(done), 64'(0));
    chk("rstmid_start", 64'(drv_start), 64'(0));
    chk("rstmid_drv", 64'({drv_rw, drv_addr, drv_wdata}), 64'(0));
    @(negedge clk);
    chk("rstmid_done2", 64'(done), 64'(0));
    chk("rstmid_rdata", 64'(rdata), 64'(0));
    rst      = 1'b0;
    drv_busy = 1'b0;
    req      = 4'b0000;
    ptr_m    = 0;
    rdata_m  = 8'h00;
    txn(4'b1001, 4'b0000, 10'h155, 8'h66, 1, 2, 8'h00, 0, 1'b0, 4'b0000, 1'b0, "post_rst0");
    txn(4'b1000, 4'b1000, 10'h2AA, 8'h77, 2, 3, 8'hC3, 3, 1'b0, 4'b0000, 1'b0, "post_rst3");

    // Randomized transactions against the model.
    for (int i = 0; i < 40; i++) begin
      r   = 4'($urandom_range(1, 15));
      rw  = 4'($urandom);
      a   = 10'($urandom);
      w   = 8'($urandom);
      rd  = 8'($urandom);
      sel = $urandom_range(0, 9);
      d   = (sel == 0) ? -1 : $urandom_range(1, ST);
      h   = (sel == 1) ? 50 : $urandom_range(1, DT);
      aft = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
      ew  = pick(r, ptr_m);
      void'(done_at(d, h, e));
      txn(r, rw, a, w, d, h, rd, ew, e, aft, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
